// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder/subtractor.
// Holds the FSM state encoding and the chunk-counter width function.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_chunk_adder.sv
// CHUNK-bit ripple of full adders; also exposes the carry into its top bit
// so the caller can form two's-complement overflow on the final chunk.
module chunk_adder #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carryin,
    output logic [CHUNK-1:0] sum,
    output logic             carryout,
    output logic             carry_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = carryin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign carryout     = c[CHUNK];
    assign carry_msb_in = c[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Chunk-serial add/subtract: accepts operands in IDLE, adds CHUNK bits per
// cycle in RUN, and presents the result in DONE until the consumer takes it.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    // Handshake: an operand transfer happens on an edge where in_valid and
    // in_ready are both high; a result transfer where out_valid and
    // out_ready are both high. Valids are never gated by the opposite ready.

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              sub_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic              carryout_reg;
    logic              overflow_reg;

    int                base;
    logic [WIDTH-1:0]  addend;
    logic [CHUNK-1:0]  slice_sum;
    logic              slice_carry;
    logic              slice_msb_carry;

    always_comb begin
        base   = int'(cnt) * CHUNK;
        addend = sub_reg ? ~b_reg : b_reg;
    end

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a           (a_reg[base +: CHUNK]),
        .b           (addend[base +: CHUNK]),
        .carryin     (carry),
        .sum         (slice_sum),
        .carryout    (slice_carry),
        .carry_msb_in(slice_msb_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)     state_next = RUN;
            RUN:     if (cnt == LAST)  state_next = DONE;
            DONE:    if (out_ready)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            carry        <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            sub_reg      <= 1'b0;
            sum_reg      <= '0;
            carryout_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        sub_reg <= sub;
                        carry   <= sub ? 1'b1 : carryin;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_reg[base +: CHUNK] <= slice_sum;
                    carry                  <= slice_carry;
                    cnt                    <= cnt + 1'b1;
                    // Only the top chunk's carries define the flags.
                    if (cnt == LAST) begin
                        carryout_reg <= slice_carry;
                        overflow_reg <= slice_msb_carry ^ slice_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign carryout  = carryout_reg;
    assign overflow  = overflow_reg;

endmodule
